// File: rtl/flag_mon_pkg.sv
// Shared types and default constants for the periodic-flag health monitor.
// The FLAG_MON_STAT_EN build option uses FAULT_CNT_W for its fault counter width.
package flag_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_EXP_PERIOD = 4;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 8;
    localparam int FAULT_CNT_W    = 16;

endpackage

// File: rtl/flag_edge_det.sv
// Rising-edge detector: registers the input once and flags 0->1 transitions.
module flag_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_d <= 1'b0;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;

endmodule

// File: rtl/flag_period_monitor.sv
// Measures flag edge-to-edge intervals, locks after a run of good intervals, flags errors and timeouts.
// Defining FLAG_MON_STAT_EN adds the saturating fault_cnt output.
module flag_period_monitor
    import flag_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_flag,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic             miss
`ifdef FLAG_MON_STAT_EN
    ,
    output logic [FAULT_CNT_W-1:0] fault_cnt
`endif
);

    localparam int                MC_W      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]    EXP_X     = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]    TOL_X     = (CNT_W + 1)'(TOL);
    localparam logic [MC_W-1:0]   LOCK_LAST = MC_W'(LOCK_CNT - 1);

    if (EXP_PERIOD < 2) begin : g_bad_exp
        $error("flag_period_monitor: EXP_PERIOD must be at least 2");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
        $error("flag_period_monitor: LOCK_CNT must be at least 1");
    end
    if ((TIMEOUT <= EXP_PERIOD + TOL) || (TIMEOUT >= (1 << CNT_W) - 1)) begin : g_bad_tmo
        $error("flag_period_monitor: TIMEOUT must lie in (EXP_PERIOD+TOL, 2^CNT_W-1)");
    end

    // Unsigned window test on a widened counter so EXP-TOL never underflows.
    function automatic logic in_tol(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] cx;
        cx = {1'b0, c};
        return ((cx + TOL_X) >= EXP_X) && (cx <= (EXP_X + TOL_X));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t          state;
    state_t          state_nxt;
    logic            ev;
    logic            match;
    logic            tmo;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [MC_W-1:0]  mcnt;
    logic [MC_W-1:0]  mcnt_nxt;
    logic            vld_nxt;
    logic            err_nxt;
    logic            miss_nxt;

    flag_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (in_flag),
        .rise (ev)
    );

    assign match = in_tol(cnt);
    // An edge landing on the timeout count is a measurement, not a miss.
    assign tmo   = (state != IDLE) && !ev && (cnt == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ev) begin
                    state_nxt = ACQ;
                end
            end
            ACQ: begin
                if (ev) begin
                    if (match && (mcnt == LOCK_LAST)) begin
                        state_nxt = LOCK;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end
            LOCK: begin
                if (ev) begin
                    if (!match) begin
                        state_nxt = ACQ;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vld_nxt  = 1'b0;
        err_nxt  = 1'b0;
        miss_nxt = 1'b0;
        cnt_nxt  = cnt;
        mcnt_nxt = mcnt;
        case (state)
            IDLE: begin
                cnt_nxt  = ev ? CNT_W'(1) : '0;
                mcnt_nxt = '0;
            end
            ACQ, LOCK: begin
                if (ev) begin
                    vld_nxt = 1'b1;
                    cnt_nxt = CNT_W'(1);
                    if (state == ACQ) begin
                        mcnt_nxt = match ? mcnt + MC_W'(1) : '0;
                    end else begin
                        err_nxt  = !match;
                        mcnt_nxt = '0;
                    end
                end else if (tmo) begin
                    miss_nxt = 1'b1;
                    cnt_nxt  = '0;
                    mcnt_nxt = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: begin
                cnt_nxt  = '0;
                mcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            mcnt       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            err        <= 1'b0;
            miss       <= 1'b0;
            locked     <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            mcnt       <= mcnt_nxt;
            period_vld <= vld_nxt;
            err        <= err_nxt;
            miss       <= miss_nxt;
            locked     <= (state_nxt == LOCK);
            if (vld_nxt) begin
                period <= cnt;
            end
        end
    end

`ifdef FLAG_MON_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt <= '0;
        end else if ((err_nxt || miss_nxt) && !(&fault_cnt)) begin
            fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_flag_period_monitor.sv
// Scoreboard bench: two monitor instances (TOL=0 and TOL=1) share one randomized flag stream.
`timescale 1ns/1ps
module tb_flag_period_monitor;

    localparam int CW = 8;
    localparam int P_EXP [2] = '{4, 4};
    localparam int P_TOL [2] = '{0, 1};
    localparam int P_LCK [2] = '{4, 4};
    localparam int P_TMO [2] = '{8, 9};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_flag;
    logic [CW-1:0] period     [2];
    logic          period_vld [2];
    logic          locked     [2];
    logic          err        [2];
    logic          miss       [2];
`ifdef FLAG_MON_STAT_EN
    logic [15:0]   fault_cnt  [2];
`endif

    always #5 clk = ~clk;

    flag_period_monitor #(
        .CNT_W(CW), .EXP_PERIOD(P_EXP[0]), .TOL(P_TOL[0]), .LOCK_CNT(P_LCK[0]), .TIMEOUT(P_TMO[0])
    ) u_dut0 (
        .clk(clk), .rst(rst), .in_flag(in_flag), .period(period[0]), .period_vld(period_vld[0]),
        .locked(locked[0]), .err(err[0]), .miss(miss[0])
`ifdef FLAG_MON_STAT_EN
        , .fault_cnt(fault_cnt[0])
`endif
    );

    flag_period_monitor #(
        .CNT_W(CW), .EXP_PERIOD(P_EXP[1]), .TOL(P_TOL[1]), .LOCK_CNT(P_LCK[1]), .TIMEOUT(P_TMO[1])
    ) u_dut1 (
        .clk(clk), .rst(rst), .in_flag(in_flag), .period(period[1]), .period_vld(period_vld[1]),
        .locked(locked[1]), .err(err[1]), .miss(miss[1])
`ifdef FLAG_MON_STAT_EN
        , .fault_cnt(fault_cnt[1])
`endif
    );

    typedef struct { int t; int k; bit vld; bit er; bit ms; int per; } evt_t;
    typedef struct { int t; int k; bit lk; int per; int fc; } cyc_t;

    evt_t ev_q[$];
    cyc_t cy_q[$];
    int   errors = 0;
    int   checks = 0;
    int   tc = 1;
    int   mon_n = 0;

    // Reference model: interval = cycle number of this edge minus cycle of the previous edge.
    bit m_prev  [2];
    int m_mode  [2];
    int m_last  [2];
    int m_match [2];
    int m_per   [2];
    int m_fc    [2];

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, k, mon_n, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit f, input int t);
        for (int k = 0; k < 2; k++) begin
            bit eg;
            bit vld;
            bit er;
            bit ms;
            int iv;
            vld = 0; er = 0; ms = 0;
            if (r) begin
                m_prev[k] = 0; m_mode[k] = 0; m_last[k] = 0;
                m_match[k] = 0; m_per[k] = 0; m_fc[k] = 0;
            end else begin
                eg = f && !m_prev[k];
                m_prev[k] = f;
                if (m_mode[k] == 0) begin
                    if (eg) begin
                        m_mode[k] = 1; m_last[k] = t; m_match[k] = 0;
                    end
                end else begin
                    iv = t - m_last[k];
                    if (eg) begin
                        vld = 1; m_per[k] = iv; m_last[k] = t;
                        if (iv >= P_EXP[k] - P_TOL[k] && iv <= P_EXP[k] + P_TOL[k]) begin
                            if (m_mode[k] == 1) begin
                                m_match[k]++;
                                if (m_match[k] == P_LCK[k]) m_mode[k] = 2;
                            end
                        end else begin
                            if (m_mode[k] == 2) er = 1;
                            m_mode[k] = 1; m_match[k] = 0;
                        end
                    end else if (iv == P_TMO[k]) begin
                        ms = 1; m_mode[k] = 0; m_match[k] = 0;
                    end
                end
                if (er || ms) m_fc[k] = (m_fc[k] < 65535) ? m_fc[k] + 1 : 65535;
            end
            if (vld || er || ms) ev_q.push_back('{t, k, vld, er, ms, m_per[k]});
            cy_q.push_back('{t, k, (m_mode[k] == 2), m_per[k], m_fc[k]});
        end
    endtask

    task automatic tick(input bit r, input bit f);
        rst = r;
        in_flag = f;
        model_step(r, f, tc);
        tc++;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap, input int w);
        for (int i = 0; i < gap; i++) tick(1'b0, i < w);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_n++;
            for (int k = 0; k < 2; k++) begin
                cyc_t c;
                evt_t e;
                bit   dev;
                if (cy_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cycle_queue inst%0d cycle %0d: no expectation available", k, mon_n);
                end else begin
                    c = cy_q.pop_front();
                    check("locked", k, int'(locked[k]), int'(c.lk));
                    check("period", k, int'(period[k]), c.per);
`ifdef FLAG_MON_STAT_EN
                    check("fault_cnt", k, int'(fault_cnt[k]), c.fc);
`endif
                end
                while (ev_q.size() > 0 && ev_q[0].t < mon_n) begin
                    e = ev_q.pop_front();
                    checks++; errors++;
                    $display("FAIL stale_event inst%0d cycle %0d: expected at cycle %0d never checked", e.k, mon_n, e.t);
                end
                dev = period_vld[k] | err[k] | miss[k];
                if (ev_q.size() > 0 && ev_q[0].t == mon_n && ev_q[0].k == k) begin
                    e = ev_q.pop_front();
                    check("period_vld", k, int'(period_vld[k]), int'(e.vld));
                    check("err", k, int'(err[k]), int'(e.er));
                    check("miss", k, int'(miss[k]), int'(e.ms));
                end else if (dev) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse inst%0d cycle %0d: vld=%0d err=%0d miss=%0d required none",
                             k, mon_n, period_vld[k], err[k], miss[k]);
                end
            end
        end
    end

    initial begin
        int gap;
        rst = 1'b1;
        in_flag = 1'b0;
        repeat (3) tick(1'b1, 1'b0);

        // Clean 4-cycle strobe to lock, one long interval, relock.
        repeat (7) pulse(4, 1);
        pulse(5, 1);
        repeat (6) pulse(4, 1);
        // Flag stops: single miss then quiet.
        tick(1'b0, 1'b1);
        repeat (14) tick(1'b0, 1'b0);
        // Held-high level counts as one edge.
        repeat (20) tick(1'b0, 1'b1);
        repeat (12) tick(1'b0, 1'b0);
        // Alternating 3/5 intervals, then lock and an edge right at the timeout count.
        repeat (6) begin
            pulse(3, 1);
            pulse(5, 2);
        end
        repeat (6) pulse(4, 1);
        pulse(8, 1);
        repeat (3) pulse(4, 1);
        pulse(9, 1);
        repeat (2) pulse(4, 1);
        // Reset while acquiring, then restart.
        tick(1'b1, 1'b0);
        repeat (6) pulse(4, 1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) tick(1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 7) gap = $urandom_range(3, 5);
            else gap = $urandom_range(2, 12);
            pulse(gap, $urandom_range(1, gap - 1));
        end
        repeat (12) tick(1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("events_left", 0, ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_period_monitor.md
Name: flag_period_monitor

Overview:
- Receive-side monitor for periodic single-cycle flags such as a divided-clock strobe (po_flag style, one pulse every N clk).
- Measures the interval between successive flag rising edges and compares it against an expected period.
- Declares lock after a run of matching intervals; reports mismatches and missing pulses.
- Sits downstream of clock-divider/strobe generators, in the same clk domain, as a health checker.

Parameters:
- CNT_W, 8, interval counter width.
- EXP_PERIOD, 4, expected interval in clk cycles; must satisfy 2 ≤ EXP_PERIOD.
- TOL, 0, allowed ± deviation in cycles.
- LOCK_CNT, 4, consecutive matching intervals required to assert locked; must be ≥ 1.
- TIMEOUT, 8, cycles without an edge that trigger a miss; must satisfy EXP_PERIOD+TOL < TIMEOUT < 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_flag  in  1  monitored flag; only rising edges count, so a held level counts once
- period  out  CNT_W  last measured interval, registered
- period_vld  out  1  one-cycle pulse when period is updated
- locked  out  1  high while in LOCK
- err  out  1  one-cycle pulse on an out-of-tolerance interval while in LOCK
- miss  out  1  one-cycle pulse on timeout

Behaviour:
- Reset is synchronous and active-high (rst), clock is clk.
- On reset:
  - period=0, period_vld=0, locked=0, err=0, miss=0.
  - Counter=0, match count=0, state=IDLE, edge-detector history=0.
- Edge detection: ev = in_flag & ~in_flag_d, where in_flag_d is in_flag registered.
- Counter:
  - On ev, counter <= 1.
  - Otherwise counter <= counter+1, saturating at all-ones.
  - The counter is held at 0 in IDLE.
- Interval definition: the counter value in the ev cycle equals the cycles since the previous edge. A pulse every 4 clk gives 4.
- A match means |counter − EXP_PERIOD| ≤ TOL. Compute this with CNT_W+1-bit unsigned compares, not signed subtraction.
- IDLE:
  - ev → ACQ, start the counter, match count=0.
  - No period_vld is produced, because there is no previous edge.
- ACQ:
  - On ev: period <= counter and period_vld pulses on the next cycle (latency 1 clk after the ev cycle).
  - If match: match count+1. On reaching LOCK_CNT → LOCK, with locked high from that same update cycle.
  - If no match: match count <= 0, stay in ACQ, no err.
- LOCK:
  - ev with match → period_vld only.
  - ev without match → period_vld and err pulse in the same cycle, locked <= 0, → ACQ, match count=0.
- Timeout (ACQ or LOCK):
  - Condition: counter == TIMEOUT and no ev in that cycle.
  - Action: miss pulses once, locked <= 0, → IDLE.
- Simultaneous ev and counter==TIMEOUT: ev wins. The interval is measured normally and there is no miss.
- The saturated counter can only be reached in IDLE-free paths if parameters are violated. Parameter checks are elaboration-time assertions.
- in_flag held high continuously: no further ev, so a timeout occurs.
- rst mid-operation: all state and outputs return to reset values on the next clk edge. Pending pulses are dropped.

Optional Feature:
- Macro: FLAG_MON_STAT_EN.
- With the macro defined:
  - Adds output fault_cnt, 16 bits.
  - Increments on each err or miss pulse, saturating at 0xFFFF.
  - Cleared only by rst.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package flag_mon_pkg:
  - State enum {IDLE, ACQ, LOCK}, 2-bit.
  - Default parameter constants.
  - FAULT_CNT_W=16.
- One sub-module, flag_edge_det: registers the input and outputs a rising-edge pulse. It uses the synchronous rst, and its history resets to 0.

Test Plan:
- Pulse every 4 clk from reset, default parameters → first edge produces no period_vld. Subsequent edges give period=4 with period_vld one clk after each edge. locked rises at the 4th period_vld. err=0, miss=0.
- Locked, then one interval of 5 (TOL=0) → period=5, err and period_vld together, locked falls. Return to 4-cycle pulses → relock after 4 more matches.
- Locked, then flag stops → miss exactly 8 clk after the last edge's counter reset (counter==8). locked=0, state IDLE, no further miss.
- in_flag held high for 20 clk → one ev only, miss at counter==8. TOL=1 run with alternating intervals 3/5 → all match, lock after 4.
- Edge arriving exactly at counter==TIMEOUT → period=8, no miss, err if locked. Assert rst mid-ACQ → all outputs 0 next cycle, and the next edge behaves as the first edge.
- FLAG_MON_STAT_EN defined → 3 err plus 2 miss gives fault_cnt=5. Preload near 0xFFFF via forced events → saturates at 0xFFFF.
